// File: rtl/ppu_pkg.sv
// Shared types and helpers for the PPU palette store: arbiter FSM states,
// the background-entry address fold and the grayscale column mask.
package ppu_pkg;

    typedef enum logic [1:0] {
        PAL_CLEAR = 2'd0,
        PAL_IDLE  = 2'd1,
        PAL_ACK   = 2'd2
    } pal_state_t;

    // Upper two bits of an entry kept by grayscale; the rest are cleared.
    localparam logic [1:0] GRAY_MASK = 2'b11;

    localparam int PAL_ADDR_MAX = 16;

    // Entries with addr[1:0]==0 alias into the lower half (backdrop mirroring).
    function automatic logic [PAL_ADDR_MAX-1:0] pal_mirror(
        input logic [PAL_ADDR_MAX-1:0] addr,
        input int                      addr_w,
        input logic                    enable
    );
        logic [PAL_ADDR_MAX-1:0] phys;
        phys = addr;
        if (enable && addr[1:0] == 2'b00) begin
            phys = addr & ~(PAL_ADDR_MAX'(1) << (addr_w - 1));
        end
        return phys;
    endfunction

endpackage

// File: rtl/palette_ram_1rw.sv
// Single-port palette RAM: one read or write per cycle, registered read data.
module palette_ram_1rw #(
    parameter int DATA_W    = 6,
    parameter int ADDR_W    = 5,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/palette_arb.sv
// Palette store arbiter: render reads own the RAM whenever requested, CPU
// req/ack accesses fill the gaps, and an optional sweep clears it after reset.
module palette_arb
    import ppu_pkg::*;
#(
    parameter int DATA_W         = 6,
    parameter int ADDR_W         = 5,
    parameter int MIRROR_BG      = 1,
    parameter int CLEAR_ON_RESET = 1,
    parameter int CLEAR_VAL      = 0,
    parameter     INIT_FILE      = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              render_en,
    input  logic [ADDR_W-1:0] render_addr,
    input  logic              grayscale,
    output logic [DATA_W-1:0] render_data,
    output logic              render_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              busy
);

    localparam int                DEPTH       = 2**ADDR_W;
    localparam logic [DATA_W-1:0] GRAY_W      = {GRAY_MASK, {(DATA_W-2){1'b0}}};
    localparam pal_state_t        RESET_STATE = (CLEAR_ON_RESET != 0) ? PAL_CLEAR : PAL_IDLE;

    pal_state_t        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              ack_prev_q, ack_prev_d;
    logic              rd_valid_q, rd_valid_d;
    logic              gray_q, gray_d;
    logic              cpu_rd_q, cpu_rd_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [ADDR_W-1:0] render_phys;
    logic [ADDR_W-1:0] cpu_phys;

    assign render_phys = ADDR_W'(pal_mirror(PAL_ADDR_MAX'(render_addr), ADDR_W, MIRROR_BG != 0));
    assign cpu_phys    = ADDR_W'(pal_mirror(PAL_ADDR_MAX'(cpu_addr), ADDR_W, MIRROR_BG != 0));

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        ack_prev_d  = (state_q == PAL_ACK);
        rd_valid_d  = 1'b0;
        gray_d      = gray_q;
        cpu_rd_d    = cpu_rd_q;
        cpu_rdata_d = cpu_rdata_q;
        ram_we      = 1'b0;
        ram_addr    = render_phys;
        ram_wdata   = cpu_wdata;

        case (state_q)
            PAL_CLEAR: begin
                ram_we    = 1'b1;
                ram_addr  = clr_cnt_q;
                ram_wdata = DATA_W'(CLEAR_VAL);
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = PAL_IDLE;
                end
            end
            default: begin
                if (render_en) begin
                    rd_valid_d = 1'b1;
                    gray_d     = grayscale;
                end else if (state_q == PAL_IDLE && cpu_req && !ack_prev_q) begin
                    // The cycle right after an ack is skipped so a held request
                    // cannot execute twice.
                    ram_we   = cpu_we;
                    ram_addr = cpu_phys;
                    cpu_rd_d = !cpu_we;
                    state_d  = PAL_ACK;
                end
                if (state_q == PAL_ACK) begin
                    state_d = PAL_IDLE;
                    if (cpu_rd_q) begin
                        cpu_rdata_d = ram_rdata;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RESET_STATE;
            clr_cnt_q   <= '0;
            ack_prev_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            gray_q      <= 1'b0;
            cpu_rd_q    <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            ack_prev_q  <= ack_prev_d;
            rd_valid_q  <= rd_valid_d;
            gray_q      <= gray_d;
            cpu_rd_q    <= cpu_rd_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    palette_ram_1rw #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // RAM read data is shared; only one client can have issued the read.
    assign render_valid = rd_valid_q;
    assign render_data  = !rd_valid_q ? '0 : (gray_q ? (ram_rdata & GRAY_W) : ram_rdata);
    assign cpu_ack      = (state_q == PAL_ACK);
    assign cpu_rdata    = (cpu_ack && cpu_rd_q) ? ram_rdata : cpu_rdata_q;
    assign busy         = (state_q == PAL_CLEAR);

endmodule

// File: tb/tb_palette_arb.sv
// Self-checking bench for palette_arb: vector table plus hand-written
// arbitration/reset sequences, results checked through a scoreboard.
module tb_palette_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       render_en;
    logic [4:0] render_addr;
    logic       grayscale;
    logic [5:0] render_data;
    logic       render_valid;
    logic       cpu_req;
    logic       cpu_we;
    logic [4:0] cpu_addr;
    logic [5:0] cpu_wdata;
    logic       cpu_ack;
    logic [5:0] cpu_rdata;
    logic       busy;

    palette_arb dut (
        .clk          (clk),
        .rst          (rst),
        .render_en    (render_en),
        .render_addr  (render_addr),
        .grayscale    (grayscale),
        .render_data  (render_data),
        .render_valid (render_valid),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_ack      (cpu_ack),
        .cpu_rdata    (cpu_rdata),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         due;
        logic [5:0] data;
    } rexp_t;

    typedef struct {
        logic       we;
        logic [5:0] data;
    } cexp_t;

    // kind: 0 = CPU write, 1 = CPU read, 2 = render read
    typedef struct {
        logic [1:0] kind;
        logic [4:0] addr;
        logic [5:0] din;
        logic       gray;
        logic [5:0] exp;
    } vec_t;

    localparam int NV = 21;
    vec_t  vt [NV];
    rexp_t rq [$];
    cexp_t cq [$];
    rexp_t re;
    cexp_t ce;

    logic [4:0] burst_addr [4];
    logic [5:0] burst_exp  [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare DUT outputs against queued expectations.
    always @(posedge clk) begin
        #2;
        if (cpu_ack) begin
            if (cq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cpu_ack_unexpected got ack=1 expected ack=0 (cycle %0d)", cyc);
            end else begin
                ce = cq.pop_front();
                if (!ce.we) begin
                    checks++;
                    if (cpu_rdata !== ce.data) begin
                        errors++;
                        $display("FAIL cpu_rdata got 0x%0h expected 0x%0h (cycle %0d)", cpu_rdata, ce.data, cyc);
                    end else begin
                        $display("txn cpu read  cyc=%0d data=0x%0h", cyc, cpu_rdata);
                    end
                end else begin
                    $display("txn cpu write cyc=%0d acked", cyc);
                end
            end
        end
        if (rq.size() > 0 && rq[0].due < cyc) begin
            re = rq.pop_front();
            checks++;
            errors++;
            $display("FAIL render_valid_missing got valid=0 expected data 0x%0h at cycle %0d", re.data, re.due);
        end
        if (render_valid) begin
            if (rq.size() == 0 || rq[0].due != cyc) begin
                checks++;
                errors++;
                $display("FAIL render_valid_unexpected got valid=1 data=0x%0h expected valid=0 (cycle %0d)", render_data, cyc);
            end else begin
                re = rq.pop_front();
                checks++;
                if (render_data !== re.data) begin
                    errors++;
                    $display("FAIL render_data got 0x%0h expected 0x%0h (cycle %0d)", render_data, re.data, cyc);
                end else begin
                    $display("txn render    cyc=%0d data=0x%0h", cyc, render_data);
                end
            end
        end
    end

    task automatic cpu_op(input logic we, input logic [4:0] a, input logic [5:0] d, input logic [5:0] exp);
        int n;
        cq.push_back(cexp_t'{we: we, data: exp});
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        n = 0;
        do begin
            step();
            n++;
        end while (!cpu_ack && n < 20);
        if (!cpu_ack) begin
            checks++;
            errors++;
            $display("FAIL cpu_ack_timeout got no ack expected ack within 20 cycles (addr 0x%0h)", a);
        end
        step();
        cpu_req = 1'b0;
    endtask

    task automatic ren(input logic [4:0] a, input logic g, input logic [5:0] exp);
        render_en   = 1'b1;
        render_addr = a;
        grayscale   = g;
        rq.push_back(rexp_t'{due: cyc + 1, data: exp});
        step();
        render_en = 1'b0;
    endtask

    // Release reset and watch the sweep while render and CPU both request.
    task automatic release_and_sweep();
        int n;
        int bad_valid;
        int bad_data;
        int bad_ack;
        n = 0;
        bad_valid = 0;
        bad_data = 0;
        bad_ack = 0;
        rst         = 1'b1;
        render_en   = 1'b1;
        render_addr = 5'h00;
        cpu_req     = 1'b1;
        cpu_we      = 1'b0;
        cpu_addr    = 5'h01;
        while (busy && n < 100) begin
            n++;
            if (render_valid) bad_valid++;
            if (render_data != 6'h00) bad_data++;
            if (cpu_ack) bad_ack++;
            step();
        end
        render_en = 1'b0;
        cpu_req   = 1'b0;
        chk("sweep_busy_cycles", n, 32);
        chk("sweep_render_valid", bad_valid, 0);
        chk("sweep_render_data", bad_data, 0);
        chk("sweep_cpu_ack", bad_ack, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_render_valid"}, render_valid, 0);
        chk({tag, "_render_data"}, render_data, 0);
        chk({tag, "_cpu_ack"}, cpu_ack, 0);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
        chk({tag, "_busy"}, busy, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int ack_at;
        int acks;

        vt[0]  = '{kind: 2'd0, addr: 5'h10, din: 6'h2A, gray: 1'b0, exp: 6'h00};
        vt[1]  = '{kind: 2'd2, addr: 5'h00, din: 6'h00, gray: 1'b0, exp: 6'h2A};
        vt[2]  = '{kind: 2'd2, addr: 5'h10, din: 6'h00, gray: 1'b0, exp: 6'h2A};
        vt[3]  = '{kind: 2'd1, addr: 5'h10, din: 6'h00, gray: 1'b0, exp: 6'h2A};
        vt[4]  = '{kind: 2'd0, addr: 5'h05, din: 6'h15, gray: 1'b0, exp: 6'h00};
        vt[5]  = '{kind: 2'd1, addr: 5'h15, din: 6'h00, gray: 1'b0, exp: 6'h00};
        vt[6]  = '{kind: 2'd2, addr: 5'h05, din: 6'h00, gray: 1'b0, exp: 6'h15};
        vt[7]  = '{kind: 2'd0, addr: 5'h1C, din: 6'h3F, gray: 1'b0, exp: 6'h00};
        vt[8]  = '{kind: 2'd2, addr: 5'h0C, din: 6'h00, gray: 1'b1, exp: 6'h30};
        vt[9]  = '{kind: 2'd2, addr: 5'h0C, din: 6'h00, gray: 1'b0, exp: 6'h3F};
        vt[10] = '{kind: 2'd1, addr: 5'h0C, din: 6'h00, gray: 1'b0, exp: 6'h3F};
        vt[11] = '{kind: 2'd0, addr: 5'h00, din: 6'h3F, gray: 1'b0, exp: 6'h00};
        vt[12] = '{kind: 2'd2, addr: 5'h00, din: 6'h00, gray: 1'b1, exp: 6'h30};
        vt[13] = '{kind: 2'd1, addr: 5'h00, din: 6'h00, gray: 1'b1, exp: 6'h3F};
        vt[14] = '{kind: 2'd2, addr: 5'h1F, din: 6'h00, gray: 1'b1, exp: 6'h00};
        vt[15] = '{kind: 2'd0, addr: 5'h1F, din: 6'h2B, gray: 1'b0, exp: 6'h00};
        vt[16] = '{kind: 2'd2, addr: 5'h1F, din: 6'h00, gray: 1'b1, exp: 6'h20};
        vt[17] = '{kind: 2'd2, addr: 5'h1F, din: 6'h00, gray: 1'b0, exp: 6'h2B};
        vt[18] = '{kind: 2'd0, addr: 5'h13, din: 6'h07, gray: 1'b0, exp: 6'h00};
        vt[19] = '{kind: 2'd2, addr: 5'h03, din: 6'h00, gray: 1'b0, exp: 6'h00};
        vt[20] = '{kind: 2'd2, addr: 5'h13, din: 6'h00, gray: 1'b0, exp: 6'h07};

        burst_addr[0] = 5'h00; burst_exp[0] = 6'h3F;
        burst_addr[1] = 5'h05; burst_exp[1] = 6'h15;
        burst_addr[2] = 5'h1F; burst_exp[2] = 6'h2B;
        burst_addr[3] = 5'h0C; burst_exp[3] = 6'h3F;

        rst         = 1'b0;
        render_en   = 1'b0;
        render_addr = '0;
        grayscale   = 1'b0;
        cpu_req     = 1'b0;
        cpu_we      = 1'b0;
        cpu_addr    = '0;
        cpu_wdata   = '0;

        // Reset state and initial sweep.
        repeat (3) step();
        chk_reset_outputs("reset");
        release_and_sweep();

        // Every entry reads back as the clear value.
        for (int a = 0; a < 32; a++) begin
            cpu_op(1'b0, 5'(a), 6'h00, 6'h00);
        end

        // Vector table.
        for (int i = 0; i < NV; i++) begin
            case (vt[i].kind)
                2'd0:    cpu_op(1'b1, vt[i].addr, vt[i].din, 6'h00);
                2'd1:    cpu_op(1'b0, vt[i].addr, 6'h00, vt[i].exp);
                default: ren(vt[i].addr, vt[i].gray, vt[i].exp);
            endcase
        end

        // Back-to-back render reads, one per cycle.
        render_en = 1'b1;
        grayscale = 1'b0;
        for (int i = 0; i < 4; i++) begin
            render_addr = burst_addr[i];
            rq.push_back(rexp_t'{due: cyc + 1, data: burst_exp[i]});
            step();
        end
        render_en = 1'b0;
        step();

        // CPU write deferred behind three render reads, then visible at n+1.
        cq.push_back(cexp_t'{we: 1'b1, data: 6'h00});
        cpu_req     = 1'b1;
        cpu_we      = 1'b1;
        cpu_addr    = 5'h0C;
        cpu_wdata   = 6'h11;
        render_en   = 1'b1;
        render_addr = 5'h0C;
        grayscale   = 1'b0;
        start = cyc;
        for (int i = 0; i < 3; i++) begin
            rq.push_back(rexp_t'{due: cyc + 1, data: 6'h3F});
            step();
        end
        render_en = 1'b0;
        ack_at = -1;
        for (int i = 0; i < 10 && ack_at < 0; i++) begin
            step();
            if (cpu_ack) ack_at = cyc;
        end
        chk("prio_ack_latency", ack_at - start, 4);
        render_en   = 1'b1;
        render_addr = 5'h0C;
        rq.push_back(rexp_t'{due: cyc + 1, data: 6'h11});
        step();
        render_en = 1'b0;
        cpu_req   = 1'b0;
        step();

        // Request held through the cycle after ack: exactly one ack, on cycle 2.
        cq.push_back(cexp_t'{we: 1'b1, data: 6'h00});
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 5'h02;
        cpu_wdata = 6'h0A;
        acks = 0;
        ack_at = 0;
        for (int i = 2; i <= 7; i++) begin
            step();
            if (i == 4) cpu_req = 1'b0;
            if (cpu_ack) begin
                acks++;
                ack_at = i;
            end
        end
        chk("hold_ack_count", acks, 1);
        chk("hold_ack_cycle", ack_at, 2);
        cpu_op(1'b0, 5'h02, 6'h00, 6'h0A);

        // Reset while a CPU read waits behind render reads.
        cpu_req     = 1'b1;
        cpu_we      = 1'b0;
        cpu_addr    = 5'h05;
        render_en   = 1'b1;
        render_addr = 5'h05;
        grayscale   = 1'b0;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            rq.push_back(rexp_t'{due: cyc + 1, data: 6'h15});
            step();
            if (cpu_ack) acks++;
        end
        chk("pending_cpu_rdata_before_reset", cpu_rdata, 6'h0A);
        rst = 1'b0;
        rq.delete();
        #1;
        chk_reset_outputs("rst_pending");
        cpu_req   = 1'b0;
        render_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (cpu_ack) acks++;
        end

        // Release, let the sweep reach count 10, then reset again.
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (cpu_ack) acks++;
        end
        chk("mid_sweep_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk_reset_outputs("rst_sweep");
        step();
        chk("rst_no_ack", acks, 0);
        release_and_sweep();

        // Contents cleared again by the restarted sweep.
        cpu_op(1'b0, 5'h05, 6'h00, 6'h00);
        cpu_op(1'b0, 5'h1F, 6'h00, 6'h00);
        ren(5'h10, 1'b0, 6'h00);
        ren(5'h13, 1'b0, 6'h00);

        repeat (3) step();
        chk("render_queue_drained", rq.size(), 0);
        chk("cpu_queue_drained", cq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
